mcb_line_xfer: RTL and testbench

// - Moves whole cache lines between a dual-port line buffer and one Spartan-6 MCB user port (cmd/wr/rd FIFOs).
// - Generalises the fixed 128-bit x16 cache/LPDDR engine: parametrised width/burst, 4-phase req/busy handshake, read timeout, sticky error.
// - Sits in the memory clock domain between the CPU-side cache (requests arrive asynchronously) and the lpddr MCB wrapper.

---
 rtl/mcb_pkg.sv | 26 ++
 rtl/mcb_line_xfer_if.sv | 46 ++++
 rtl/sync2.sv | 22 ++
 rtl/mcb_line_xfer.sv | 182 ++++++++++++++++++
 tb/tb_mcb_line_xfer.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcb_pkg.sv
// Shared types and helpers for the MCB line-transfer engine.
package mcb_pkg;

  localparam logic [2:0] MCB_INSTR_WR = 3'b000;
  localparam logic [2:0] MCB_INSTR_RD = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    WFILL,
    WCMD,
    WDRAIN,
    RCMD,
    RXFER,
    DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mcb_line_xfer_if.sv
// Line-buffer port plus one MCB user port (cmd, write FIFO, read FIFO).
interface mcb_line_xfer_if #(
  parameter int DATA_W      = 128,
  parameter int BYTE_ADDR_W = 30,
  parameter int BUF_AW      = 4
);
  logic [BUF_AW-1:0]      buf_addr;
  logic                   buf_en;
  logic                   buf_we;
  logic [DATA_W-1:0]      buf_wdata;
  logic [DATA_W-1:0]      buf_rdata;
  logic                   cmd_en;
  logic [2:0]             cmd_instr;
  logic [5:0]             cmd_bl;
  logic [BYTE_ADDR_W-1:0] cmd_byte_addr;
  logic                   cmd_full;
  logic                   mcb_wr_en;
  logic [DATA_W-1:0]      mcb_wr_data;
  logic [DATA_W/8-1:0]    mcb_wr_mask;
  logic                   mcb_wr_empty;
  logic                   mcb_rd_en;
  logic [DATA_W-1:0]      mcb_rd_data;
  logic                   mcb_rd_empty;

  modport master (
    output buf_addr, buf_en, buf_we, buf_wdata,
    input  buf_rdata,
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    input  cmd_full,
    output mcb_wr_en, mcb_wr_data, mcb_wr_mask,
    input  mcb_wr_empty,
    output mcb_rd_en,
    input  mcb_rd_data, mcb_rd_empty
  );

  modport slave (
    input  buf_addr, buf_en, buf_we, buf_wdata,
    output buf_rdata,
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
    output cmd_full,
    input  mcb_wr_en, mcb_wr_data, mcb_wr_mask,
    output mcb_wr_empty,
    input  mcb_rd_en,
    output mcb_rd_data, mcb_rd_empty
  );
endinterface

// File: rtl/sync2.sv
// Two-flop level synchroniser for the asynchronous request lines.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;
endmodule

// File: rtl/mcb_line_xfer.sv
// Moves whole cache lines between a dual-port line buffer and one MCB user port,
// with 4-phase req/busy handshakes, a read timeout and a sticky error flag.
module mcb_line_xfer
  import mcb_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int BURST_LEN   = 16,
  parameter int LINE_ADDR_W = 16,
  parameter int BYTE_ADDR_W = 30,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   calib_done,
  input  logic                   wr_req,
  input  logic                   rd_req,
  input  logic [LINE_ADDR_W-1:0] waddr,
  input  logic [LINE_ADDR_W-1:0] raddr,
  output logic                   wr_busy,
  output logic                   rd_busy,
  output logic                   err,
  mcb_line_xfer_if.master        bus
);
  localparam int BEAT_W  = clog2(BURST_LEN);
  localparam int LB_LOG2 = clog2(BURST_LEN * DATA_W / 8);
  localparam int TO_W    = clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  state_t                 state_reg, state_next;
  logic [BEAT_W-1:0]      beat_reg, beat_next;
  logic [TO_W-1:0]        to_reg, to_next;
  logic                   push_reg, push_next;
  logic                   wr_busy_reg, wr_busy_next;
  logic                   rd_busy_reg, rd_busy_next;
  logic                   err_reg, err_next;
  logic [2:0]             instr_reg, instr_next;
  logic [BYTE_ADDR_W-1:0] addr_reg, addr_next;

  logic                   wr_s, rd_s, wr_ok, rd_ok, pop;
  logic                   buf_en_c, buf_we_c, cmd_en_c;
  logic [BEAT_W-1:0]      buf_addr_c;
  logic [DATA_W-1:0]      buf_wdata_c;

  sync2 u_wr_sync (.clk(clk), .reset(reset), .d(wr_req), .q(wr_s));
  sync2 u_rd_sync (.clk(clk), .reset(reset), .d(rd_req), .q(rd_s));

  // A write also needs an empty write FIFO so its BURST_LEN pushes always fit.
  assign wr_ok = wr_s & ~wr_busy_reg & calib_done & bus.mcb_wr_empty & ~bus.cmd_full;
  assign rd_ok = rd_s & ~rd_busy_reg & calib_done & ~bus.cmd_full;
  assign pop   = (state_reg == RXFER) & ~bus.mcb_rd_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      beat_reg    <= '0;
      to_reg      <= '0;
      push_reg    <= 1'b0;
      wr_busy_reg <= 1'b0;
      rd_busy_reg <= 1'b0;
      err_reg     <= 1'b0;
      instr_reg   <= '0;
      addr_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      beat_reg    <= beat_next;
      to_reg      <= to_next;
      push_reg    <= push_next;
      wr_busy_reg <= wr_busy_next;
      rd_busy_reg <= rd_busy_next;
      err_reg     <= err_next;
      instr_reg   <= instr_next;
      addr_reg    <= addr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    beat_next    = beat_reg;
    to_next      = to_reg;
    push_next    = 1'b0;
    wr_busy_next = wr_busy_reg;
    rd_busy_next = rd_busy_reg;
    err_next     = err_reg;
    instr_next   = instr_reg;
    addr_next    = addr_reg;
    buf_en_c     = 1'b0;
    buf_we_c     = 1'b0;
    buf_addr_c   = '0;
    buf_wdata_c  = '0;
    cmd_en_c     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (wr_ok) begin
          state_next   = WFILL;
          wr_busy_next = 1'b1;
          instr_next   = MCB_INSTR_WR;
          addr_next    = BYTE_ADDR_W'(waddr) << LB_LOG2;
          beat_next    = '0;
        end else if (rd_ok) begin
          state_next   = RCMD;
          rd_busy_next = 1'b1;
          instr_next   = MCB_INSTR_RD;
          addr_next    = BYTE_ADDR_W'(raddr) << LB_LOG2;
          beat_next    = '0;
        end
      end
      WFILL: begin
        buf_en_c   = 1'b1;
        buf_addr_c = beat_reg;
        push_next  = 1'b1;
        if (beat_reg == LAST_BEAT) begin
          beat_next  = '0;
          state_next = WCMD;
        end else begin
          beat_next = beat_reg + BEAT_W'(1);
        end
      end
      WCMD: begin
        // First cycle here still carries the last push; command goes out after it.
        if (!push_reg) begin
          cmd_en_c   = 1'b1;
          state_next = WDRAIN;
        end
      end
      WDRAIN: begin
        if (bus.mcb_wr_empty) state_next = DONE;
      end
      RCMD: begin
        cmd_en_c   = 1'b1;
        to_next    = '0;
        state_next = RXFER;
      end
      RXFER: begin
        if (pop) begin
          buf_en_c    = 1'b1;
          buf_we_c    = 1'b1;
          buf_addr_c  = beat_reg;
          buf_wdata_c = bus.mcb_rd_data;
          to_next     = '0;
          if (beat_reg == LAST_BEAT) begin
            beat_next  = '0;
            state_next = DONE;
          end else begin
            beat_next = beat_reg + BEAT_W'(1);
          end
        end else if (to_reg == TO_LAST) begin
          err_next   = 1'b1;
          beat_next  = '0;
          state_next = DONE;
        end else begin
          to_next = to_reg + TO_W'(1);
        end
      end
      DONE: begin
        if ((wr_busy_reg & ~wr_s) | (rd_busy_reg & ~rd_s)) begin
          wr_busy_next = 1'b0;
          rd_busy_next = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_busy           = wr_busy_reg;
  assign rd_busy           = rd_busy_reg;
  assign err               = err_reg;
  assign bus.buf_en        = buf_en_c;
  assign bus.buf_we        = buf_we_c;
  assign bus.buf_addr      = buf_addr_c;
  assign bus.buf_wdata     = buf_wdata_c;
  assign bus.cmd_en        = cmd_en_c;
  assign bus.cmd_instr     = instr_reg;
  assign bus.cmd_bl        = 6'(BURST_LEN - 1);
  assign bus.cmd_byte_addr = addr_reg;
  assign bus.mcb_wr_en     = push_reg;
  assign bus.mcb_wr_data   = push_reg ? bus.buf_rdata : '0;
  assign bus.mcb_wr_mask   = '0;
  assign bus.mcb_rd_en     = pop;
endmodule

// File: tb/tb_mcb_line_xfer.sv
// Directed bench for mcb_line_xfer: line buffer, write FIFO and read FIFO modelled here.
module tb_mcb_line_xfer;
  localparam int DW  = 128;
  localparam int BL  = 16;
  localparam int LAW = 16;
  localparam int BAW = 30;
  localparam int TO  = 16;

  logic clk = 1'b0, reset = 1'b1, calib_done = 1'b1, wr_req = 1'b0, rd_req = 1'b0;
  logic [LAW-1:0] waddr = '0, raddr = '0;
  logic wr_busy, rd_busy, err;
  logic rd_gate = 1'b0, wr_empty = 1'b1;

  logic [DW-1:0] src_mem [BL];
  logic [DW-1:0] rd_mem  [BL];
  logic [DW-1:0] rdata_q = '0;
  int rd_base = 0, rd_limit = 0;

  int wr_cnt = 0, cmd_cnt = 0, bw_cnt = 0, pop_cnt = 0, bad_pop = 0;
  logic [DW-1:0]  wr_log [128];
  logic [3:0]     ba_log [128];
  logic [DW-1:0]  bd_log [128];
  logic [2:0]     ci_log [16];
  logic [BAW-1:0] ca_log [16];
  logic [5:0]     cb_log [16];
  int             cw_log [16];

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mcb_line_xfer_if #(.DATA_W(DW), .BYTE_ADDR_W(BAW), .BUF_AW(4)) bus ();

  mcb_line_xfer #(
    .DATA_W(DW), .BURST_LEN(BL), .LINE_ADDR_W(LAW), .BYTE_ADDR_W(BAW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done),
    .wr_req(wr_req), .rd_req(rd_req), .waddr(waddr), .raddr(raddr),
    .wr_busy(wr_busy), .rd_busy(rd_busy), .err(err), .bus(bus)
  );

  assign bus.buf_rdata    = rdata_q;
  assign bus.cmd_full     = 1'b0;
  assign bus.mcb_wr_empty = wr_empty;
  assign bus.mcb_rd_empty = !(rd_gate && (pop_cnt < rd_limit));
  assign bus.mcb_rd_data  = rd_mem[4'(pop_cnt - rd_base)];

  always @(posedge clk) begin
    if (bus.buf_en && !bus.buf_we) rdata_q <= src_mem[bus.buf_addr];
    if (bus.buf_en && bus.buf_we) begin
      ba_log[7'(bw_cnt)] <= bus.buf_addr;
      bd_log[7'(bw_cnt)] <= bus.buf_wdata;
      bw_cnt <= bw_cnt + 1;
    end
    if (bus.mcb_wr_en) begin
      wr_log[7'(wr_cnt)] <= bus.mcb_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.cmd_en) begin
      ci_log[4'(cmd_cnt)] <= bus.cmd_instr;
      ca_log[4'(cmd_cnt)] <= bus.cmd_byte_addr;
      cb_log[4'(cmd_cnt)] <= bus.cmd_bl;
      cw_log[4'(cmd_cnt)] <= wr_cnt;
      cmd_cnt <= cmd_cnt + 1;
    end
    if (bus.mcb_rd_en) begin
      pop_cnt <= pop_cnt + 1;
      if (bus.mcb_rd_empty) bad_pop <= bad_pop + 1;
    end
  end

  task automatic wait_level(input int which, input logic lvl, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget && n < 0; i++) begin
      @(negedge clk);
      if (((which == 0) ? wr_busy : (which == 1) ? rd_busy : err) === lvl) n = i;
    end
  endtask

  task automatic wait_count(input int which, input int target, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget && n < 0; i++) begin
      @(negedge clk);
      if (((which == 0) ? cmd_cnt : pop_cnt) >= target) n = i;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({wr_busy, rd_busy, err, bus.buf_en, bus.buf_we, bus.mcb_wr_en, bus.mcb_rd_en, bus.cmd_en} !== 8'h00) begin
      failures++; $display("FAIL reset_strobes: got %b required 00000000",
        {wr_busy, rd_busy, err, bus.buf_en, bus.buf_we, bus.mcb_wr_en, bus.mcb_rd_en, bus.cmd_en});
    end
    checks++;
    if ({bus.buf_addr, bus.cmd_instr, bus.cmd_byte_addr} !== '0) begin
      failures++; $display("FAIL reset_addr: buf_addr=%h instr=%h byte_addr=%h required 0",
        bus.buf_addr, bus.cmd_instr, bus.cmd_byte_addr);
    end
    checks++;
    if ((bus.buf_wdata | bus.mcb_wr_data) !== '0) begin
      failures++; $display("FAIL reset_data: buf_wdata=%h mcb_wr_data=%h required 0", bus.buf_wdata, bus.mcb_wr_data);
    end
    checks++;
    if (bus.cmd_bl !== 6'd15) begin
      failures++; $display("FAIL cmd_bl: got %0d required 15", bus.cmd_bl);
    end
    checks++;
    if (bus.mcb_wr_mask !== '0) begin
      failures++; $display("FAIL wr_mask: got %h required 0", bus.mcb_wr_mask);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_write();
    int s0, c0, n;
    s0 = wr_cnt; c0 = cmd_cnt;
    waddr = 16'h1234; wr_req = 1'b1;
    wait_level(0, 1'b1, 6, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL write_accept: wr_busy=%b after 6 cycles, required 1", wr_busy); end
    wr_empty = 1'b0;
    wait_count(0, c0 + 1, 40, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL write_cmd: cmd count %0d required %0d", cmd_cnt - c0, 1); end
    checks++;
    if (wr_cnt - s0 !== 16) begin failures++; $display("FAIL write_push_count: got %0d required 16", wr_cnt - s0); end
    for (int i = 0; i < BL; i++) begin
      checks++;
      if (wr_log[7'(s0 + i)] !== DW'(i)) begin
        failures++; $display("FAIL write_data beat %0d: got %h required %h", i, wr_log[7'(s0 + i)], DW'(i));
      end
    end
    checks++;
    if ({ci_log[4'(c0)], ca_log[4'(c0)], cb_log[4'(c0)]} !== {3'b000, 30'h0012_3400, 6'd15}) begin
      failures++; $display("FAIL write_cmd_fields: instr=%b addr=%h bl=%0d required 000 0123400 15",
        ci_log[4'(c0)], ca_log[4'(c0)], cb_log[4'(c0)]);
    end
    checks++;
    if (cw_log[4'(c0)] !== s0 + 16) begin
      failures++; $display("FAIL write_cmd_after_push: pushes before cmd %0d required 16", cw_log[4'(c0)] - s0);
    end
    wr_req = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_busy !== 1'b1) begin failures++; $display("FAIL write_drain_hold: wr_busy=%b required 1", wr_busy); end
    wr_empty = 1'b1;
    wait_level(0, 1'b0, 6, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL write_busy_drop: wr_busy=%b required 0", wr_busy); end
    $display("write: waddr=1234 pushes=%0d cmds=%0d", wr_cnt - s0, cmd_cnt - c0);
  endtask

  task automatic test_refill();
    int b0, p0, c0, bad0, n;
    logic [31:0] gaps;
    gaps = 32'h0000_7083;
    b0 = bw_cnt; p0 = pop_cnt; c0 = cmd_cnt; bad0 = bad_pop;
    rd_gate = 1'b0; rd_base = pop_cnt; rd_limit = pop_cnt + 16;
    raddr = 16'h0001; rd_req = 1'b1;
    wait_count(0, c0 + 1, 10, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL refill_cmd: cmd count %0d required 1", cmd_cnt - c0); end
    for (int k = 0; k < 40 && pop_cnt < p0 + 16; k++) begin
      rd_gate = !gaps[k];
      @(negedge clk);
    end
    rd_gate = 1'b0;
    checks++;
    if (pop_cnt - p0 !== 16) begin failures++; $display("FAIL refill_pops: got %0d required 16", pop_cnt - p0); end
    checks++;
    if (bw_cnt - b0 !== 16) begin failures++; $display("FAIL refill_buf_writes: got %0d required 16", bw_cnt - b0); end
    checks++;
    if (bad_pop !== bad0) begin failures++; $display("FAIL refill_pop_empty: got %0d required 0", bad_pop - bad0); end
    checks++;
    if ({ci_log[4'(c0)], ca_log[4'(c0)]} !== {3'b001, 30'h100}) begin
      failures++; $display("FAIL refill_cmd_fields: instr=%b addr=%h required 001 0000100", ci_log[4'(c0)], ca_log[4'(c0)]);
    end
    for (int i = 0; i < BL; i++) begin
      checks++;
      if ({ba_log[7'(b0 + i)], bd_log[7'(b0 + i)]} !== {4'(i), rd_mem[i]}) begin
        failures++; $display("FAIL refill_beat %0d: addr=%0d data=%h required addr=%0d data=%h",
          i, ba_log[7'(b0 + i)], bd_log[7'(b0 + i)], i, rd_mem[i]);
      end
    end
    checks++;
    if ({err, rd_busy} !== 2'b01) begin failures++; $display("FAIL refill_status: err,rd_busy=%b required 01", {err, rd_busy}); end
    rd_req = 1'b0;
    wait_level(1, 1'b0, 6, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL refill_busy_drop: rd_busy=%b required 0", rd_busy); end
    $display("refill: raddr=0001 pops=%0d buffer writes=%0d", pop_cnt - p0, bw_cnt - b0);
  endtask

  task automatic test_back_to_back();
    int c0, p0, s0, n;
    c0 = cmd_cnt; p0 = pop_cnt; s0 = wr_cnt;
    rd_base = pop_cnt; rd_limit = pop_cnt + 16; rd_gate = 1'b1;
    waddr = 16'h0042; raddr = 16'h0077;
    wr_req = 1'b1; rd_req = 1'b1;
    wait_level(0, 1'b1, 6, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL b2b_write_first: wr_busy=%b required 1", wr_busy); end
    checks++;
    if (rd_busy !== 1'b0) begin failures++; $display("FAIL b2b_rd_blocked: rd_busy=%b required 0", rd_busy); end
    wait_count(0, c0 + 1, 40, n);
    checks++;
    if ({ci_log[4'(c0)], ca_log[4'(c0)]} !== {3'b000, 30'h4200}) begin
      failures++; $display("FAIL b2b_wcmd: instr=%b addr=%h required 000 0004200", ci_log[4'(c0)], ca_log[4'(c0)]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_busy, rd_busy} !== 2'b10) begin failures++; $display("FAIL b2b_hold: wr,rd busy=%b required 10", {wr_busy, rd_busy}); end
    wr_req = 1'b0;
    wait_level(0, 1'b0, 6, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL b2b_wr_drop: wr_busy=%b required 0", wr_busy); end
    wait_level(1, 1'b1, 6, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL b2b_rd_accept: rd_busy=%b required 1", rd_busy); end
    wait_count(1, p0 + 16, 40, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL b2b_pops: got %0d required 16", pop_cnt - p0); end
    checks++;
    if ({ci_log[4'(c0 + 1)], ca_log[4'(c0 + 1)]} !== {3'b001, 30'h7700}) begin
      failures++; $display("FAIL b2b_rcmd: instr=%b addr=%h required 001 0007700", ci_log[4'(c0 + 1)], ca_log[4'(c0 + 1)]);
    end
    checks++;
    if (wr_cnt - s0 !== 16) begin failures++; $display("FAIL b2b_pushes: got %0d required 16", wr_cnt - s0); end
    rd_req = 1'b0;
    wait_level(1, 1'b0, 6, n);
    rd_gate = 1'b0;
    checks++;
    if (n < 0) begin failures++; $display("FAIL b2b_rd_drop: rd_busy=%b required 0", rd_busy); end
    $display("back_to_back: cmds=%0d pushes=%0d pops=%0d", cmd_cnt - c0, wr_cnt - s0, pop_cnt - p0);
  endtask

  task automatic test_timeout();
    int c0, p0, n;
    c0 = cmd_cnt; p0 = pop_cnt;
    rd_gate = 1'b0; raddr = 16'h0003; rd_req = 1'b1;
    wait_count(0, c0 + 1, 10, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL timeout_cmd: cmd count %0d required 1", cmd_cnt - c0); end
    repeat (15) @(negedge clk);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL timeout_early: err=%b after 15 empty cycles, required 0", err); end
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL timeout_err: err=%b after 16 empty cycles, required 1", err); end
    checks++;
    if ({rd_busy, 32'(pop_cnt - p0)} !== {1'b1, 32'd0}) begin
      failures++; $display("FAIL timeout_state: rd_busy=%b pops=%0d required 1 and 0", rd_busy, pop_cnt - p0);
    end
    rd_req = 1'b0;
    wait_level(1, 1'b0, 6, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL timeout_busy_drop: rd_busy=%b required 0", rd_busy); end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL timeout_sticky: err=%b required 1", err); end
    $display("timeout: err=%b pops=%0d", err, pop_cnt - p0);
  endtask

  task automatic test_calib();
    int c0, s0, n;
    calib_done = 1'b0; c0 = cmd_cnt; s0 = wr_cnt;
    waddr = 16'h0100; wr_req = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if ({wr_busy, 32'(cmd_cnt - c0), 32'(wr_cnt - s0)} !== 65'd0) begin
      failures++; $display("FAIL calib_block: wr_busy=%b cmds=%0d pushes=%0d required 0", wr_busy, cmd_cnt - c0, wr_cnt - s0);
    end
    calib_done = 1'b1;
    wait_level(0, 1'b1, 3, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL calib_accept: wr_busy=%b 3 cycles after calib_done, required 1", wr_busy); end
    wait_count(0, c0 + 1, 40, n);
    checks++;
    if ({ca_log[4'(c0)], 32'(wr_cnt - s0)} !== {30'h01_0000, 32'd16}) begin
      failures++; $display("FAIL calib_write: addr=%h pushes=%0d required 0010000 and 16", ca_log[4'(c0)], wr_cnt - s0);
    end
    wr_req = 1'b0;
    wait_level(0, 1'b0, 6, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL calib_busy_drop: wr_busy=%b required 0", wr_busy); end
    $display("calib: accept after %0d cycles", n);
  endtask

  task automatic test_mid_reset();
    int c0, s0, n;
    bit found;
    found = 1'b0;
    waddr = 16'h00AB; wr_req = 1'b1;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (bus.buf_en === 1'b1 && bus.buf_addr === 4'd7) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midreset_reach: beat 7 not seen, required within 30 cycles"); end
    reset = 1'b1;
    #1;
    checks++;
    if ({wr_busy, rd_busy, err, bus.buf_en, bus.buf_we, bus.mcb_wr_en, bus.mcb_rd_en, bus.cmd_en} !== 8'h00) begin
      failures++; $display("FAIL midreset_strobes: got %b required 00000000",
        {wr_busy, rd_busy, err, bus.buf_en, bus.buf_we, bus.mcb_wr_en, bus.mcb_rd_en, bus.cmd_en});
    end
    checks++;
    if ({bus.buf_addr, bus.cmd_instr, bus.cmd_byte_addr, bus.mcb_wr_data} !== '0) begin
      failures++; $display("FAIL midreset_values: buf_addr=%h byte_addr=%h wr_data=%h required 0",
        bus.buf_addr, bus.cmd_byte_addr, bus.mcb_wr_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s0 = wr_cnt; c0 = cmd_cnt;
    wait_count(0, c0 + 1, 40, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL midreset_cmd: cmd count %0d required 1", cmd_cnt - c0); end
    checks++;
    if ({ca_log[4'(c0)], 32'(wr_cnt - s0)} !== {30'h0000_AB00, 32'd16}) begin
      failures++; $display("FAIL midreset_write: addr=%h pushes=%0d required 000AB00 and 16", ca_log[4'(c0)], wr_cnt - s0);
    end
    for (int i = 0; i < BL; i++) begin
      checks++;
      if (wr_log[7'(s0 + i)] !== DW'(i)) begin
        failures++; $display("FAIL midreset_data beat %0d: got %h required %h", i, wr_log[7'(s0 + i)], DW'(i));
      end
    end
    wr_req = 1'b0;
    wait_level(0, 1'b0, 6, n);
    checks++;
    if (n < 0) begin failures++; $display("FAIL midreset_busy_drop: wr_busy=%b required 0", wr_busy); end
    $display("mid_reset: fresh write pushes=%0d", wr_cnt - s0);
  endtask

  initial begin
    for (int i = 0; i < BL; i++) begin
      src_mem[i] = DW'(i);
      rd_mem[i]  = {4{32'(32'hC0DE_0000 + i)}};
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_write();
    test_refill();
    test_back_to_back();
    test_timeout();
    test_calib();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1, "watchdog");
  end
endmodule
